// File: rtl/seq101_pkg.sv
// Shared definitions for the 101-framed serial link (transmitter and detector).
package seq101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    STUFF,
    TRAIL
  } seq101_state_t;

  localparam logic [2:0] PREAMBLE      = 3'b101;
  localparam int         TRAIL_LEN     = 2;
  localparam logic [1:0] STUFF_TRIGGER = 2'b10;

endpackage

// File: rtl/seq101_tx.sv
// Serial frame transmitter: 101 preamble, zero-stuffed MSB-first payload, 00 trailer.
// state_reg names the kind of bit currently driven on out.
module seq101_tx
  import seq101_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

  seq101_state_t     state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [1:0]        hist_reg, hist_next;
  logic              out_reg, out_next;
  logic              out_valid_reg, out_valid_next;
  logic              done_reg, done_next;

  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  shamt;
  logic              payload_step;
  logic              emit;
  logic              emit_bit;

  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  // Left-align the payload so the next bit to send is always the MSB.
  assign shamt       = MAX_LEN - len_clamped;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    shift_next     = shift_reg;
    hist_next      = hist_reg;
    out_next       = 1'b0;
    out_valid_next = 1'b0;
    done_next      = 1'b0;
    payload_step   = 1'b0;
    emit           = 1'b0;
    emit_bit       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          state_next = PRE;
          cnt_next   = 2'd2;
          rem_next   = len_clamped;
          shift_next = load_data << shamt;
          hist_next  = 2'b00;
          emit       = 1'b1;
          emit_bit   = PREAMBLE[2];
        end
      end
      PRE: begin
        if (cnt_reg != 2'd0) begin
          cnt_next = cnt_reg - 2'd1;
          emit     = 1'b1;
          emit_bit = (cnt_reg == 2'd2) ? PREAMBLE[1] : PREAMBLE[0];
        end else begin
          payload_step = 1'b1;
        end
      end
      DATA, STUFF: payload_step = 1'b1;
      TRAIL: begin
        if (cnt_reg != 2'd0) begin
          cnt_next  = cnt_reg - 2'd1;
          emit      = 1'b1;
          emit_bit  = 1'b0;
          done_next = (cnt_reg == 2'd1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Remaining count is checked first so no stuff bit follows the last payload bit.
    if (payload_step) begin
      emit = 1'b1;
      if (rem_reg == '0) begin
        state_next = TRAIL;
        cnt_next   = 2'(TRAIL_LEN - 1);
        emit_bit   = 1'b0;
      end else if (hist_reg == STUFF_TRIGGER) begin
        state_next = STUFF;
        emit_bit   = 1'b0;
      end else begin
        state_next = DATA;
        emit_bit   = shift_reg[DATA_W-1];
        shift_next = shift_reg << 1;
        rem_next   = rem_reg - LEN_W'(1);
      end
    end

    if (emit) begin
      out_next       = emit_bit;
      out_valid_next = 1'b1;
      hist_next      = {hist_next[0], emit_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      shift_reg     <= '0;
      hist_reg      <= 2'b00;
      out_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      shift_reg     <= shift_next;
      hist_reg      <= hist_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      done_reg      <= done_next;
    end
  end

  assign load_ready = (state_reg == IDLE);
  assign out        = out_reg;
  assign out_valid  = out_valid_reg;
  assign done       = done_reg;

endmodule

// File: doc/seq101_tx.md
# seq101_tx

Serial frame transmitter that produces the bit stream consumed by the Mealy "101" sequence detector. A parallel payload is accepted over a valid/ready handshake and sent MSB-first on a single serial line. Each frame is a fixed `101` preamble, the payload with zero-stuffing so `101` never appears outside the preamble, and a `00` trailer. The detector therefore fires exactly once per frame, on the last preamble bit.

## Interface
- `DATA_W`, default 8: maximum payload bits per frame.
- `LEN_W`, default `$clog2(DATA_W+1)`: width of `load_len`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  payload offered.
- `load_ready`  out  1  block can accept a payload.
- `load_data`  in  DATA_W  payload; bits `[load_len-1:0]` are sent, MSB first.
- `load_len`  in  LEN_W  payload length, 0..DATA_W; values above DATA_W are clamped to DATA_W.
- `out`  out  1  serial bit, registered.
- `out_valid`  out  1  `out` carries a frame bit (preamble, payload, stuff or trailer).
- `done`  out  1  one-cycle pulse coinciding with the final trailer bit.

## Operation
- States: IDLE, PRE, DATA, STUFF, TRAIL.
- IDLE
  - `load_ready=1`, `out=0`, `out_valid=0`.
  - Accept on `load_valid && load_ready`: latch data and clamped length, clear bit history `hist` to `2'b00`, go to PRE.
- PRE: emit 1, 0, 1 on three consecutive cycles, using bit counter 2→0.
- After PRE: go to DATA if length > 0, otherwise go to TRAIL.
- DATA / STUFF, evaluated before each payload bit:
  - `hist` holds the last two emitted bits. It is updated on every emitted bit, preamble included.
  - If `hist==2'b10`, emit a stuffed 0 (STUFF) and do not consume a payload bit.
  - Otherwise emit the next payload bit (DATA) and decrement the remaining count.
  - After the last payload bit, go to TRAIL. No stuff bit is appended after the final payload bit.
- TRAIL: emit 0, 0. `done=1` on the second trailer bit; next state is IDLE.
- `load_valid` outside IDLE is ignored. `load_data` and `load_len` are sampled only on acceptance.
- Frame length = 3 + len + stuffs + 2. Worst case (alternating payload) is about 3 + 1.5·DATA_W + 2.
- Reset values: `out=0`, `out_valid=0`, `done=0`, state IDLE (so `load_ready=1`), `hist=00`, counters 0.

## Timing
- Acceptance edge N: first preamble bit is on `out` (with `out_valid=1`) during cycle N+1.
- `out_valid` stays high continuously from the first preamble bit through the second trailer bit.
- `load_ready` is high from the cycle after the `done` cycle. Minimum frame-to-frame gap is 1 idle cycle, during which `out=0`.
- Reset asserted mid-frame: at the next edge the state is IDLE, `out=0`, `out_valid=0`. The partial frame is dropped with no trailer and no `done`.
- Reset has priority over a simultaneous accept.
- `load_ready` is a combinational decode of state==IDLE. All other outputs are registered.

## Structure
- Package `seq101_pkg`:
  - state enum `seq101_state_t`;
  - `PREAMBLE = 3'b101`;
  - `TRAIL_LEN = 2`;
  - `STUFF_TRIGGER = 2'b10`.
- A future detector rework imports the same package.
- No sub-module. This is a single FSM with a shift register, bit counter and 2-bit history, about 150–250 lines.

## Test plan
- Reset held 3 cycles, then released → `out=0`, `out_valid=0`, `done=0`, `load_ready=1`. No activity with `load_valid=0`.
- `load_data=8'hFF`, `load_len=8` → `out` = 1,0,1, eight 1s, 0,0 (13 bits, no stuffing). `done` on bit 13. `load_ready` high on the following cycle.
- `load_data=8'hAA`, `load_len=8` → 101 1 0 [0] 1 0 [0] 1 0 [0] 1 0 00. That is 16 bits with 3 stuffs, and no `101` after bit 3.
- `load_len=3`, `load_data=8'h02` → 101 0 [0] 1 0 00 (9 bits). `load_len=0` → 10100 (5 bits). `load_len=12` → treated as 8.
- `reset` pulsed during the fifth payload bit of an `8'hAA` frame → `out_valid=0` on the next edge, no `done`. A new frame is then accepted and sent correctly.
- 200 random back-to-back frames looped into the Mealy 101 detector → detector `out` pulses exactly once per frame, in the cycle of the third preamble bit. Frame bit count matches 5 + len + expected stuffs.
